// File: rtl/simon_3264_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : simon_3264_out_buffer
//  Purpose  : Completes the SIMON_3264 core's doneData/readData handshake and
//             buffers each tagged result in a FIFO for a valid/ready host port.
//  Revision : 1.0  initial release
// ============================================================================
module simon_3264_out_buffer #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic             doneData,
    input  logic [2*N-1:0]   outData,
    input  logic             enc_dec,
    output logic             readData,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_data,
    output logic             out_enc_dec,
    output logic [AW:0]      count,
    output logic             full,
    output logic [CW-1:0]    n_captured
);

    localparam int         c_EW   = 2 * N + 1;
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_ACK  = 1'b1;

    logic [0:0]      r_state;
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [AW:0]     r_count;
    logic [CW-1:0]   r_nCaptured;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Full comes from the start-of-cycle count, so a same-cycle pop never frees a slot for a push.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = (r_state == c_IDLE) && doneData && !w_full && !clr;
    assign w_pop   = !w_empty && out_ready && !clr;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_push)    r_state <= c_ACK;
                c_ACK:   if (!doneData) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= {outData, enc_dec};
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_nCaptured <= '0;
        end else if (w_push) begin
            r_nCaptured <= r_nCaptured + CW'(1);
        end
    end

    assign readData                = (r_state == c_ACK);
    assign out_valid               = !w_empty;
    assign {out_data, out_enc_dec} = r_mem[r_rdPtr];
    assign count                   = r_count;
    assign full                    = w_full;
    assign n_captured              = r_nCaptured;

endmodule
`default_nettype wire

// File: tb/tb_simon_3264_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_3264_out_buffer
//  Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//             compared every cycle against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_simon_3264_out_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          R = 1'b1;
    logic          doneData = 1'b0;
    logic [31:0]   outData = '0;
    logic          enc_dec = 1'b0;
    logic          clr = 1'b0;
    logic          out_ready = 1'b0;
    logic          readData;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_enc_dec;
    logic [AW:0]   count;
    logic          full;
    logic [CW-1:0] n_captured;

    simon_3264_out_buffer #(.N(N), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .R(R), .doneData(doneData), .outData(outData), .enc_dec(enc_dec),
        .readData(readData), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_enc_dec(out_enc_dec), .count(count), .full(full),
        .n_captured(n_captured)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {data,tag}, whether the core is awaiting release, and a capture tally.
    logic [32:0] mq[$];
    bit          mAck;
    int          mCap;

    initial begin
        bit isFull, doPush, doPop;
        mAck = 0;
        mCap = 0;
        forever begin
            @(posedge clk);
            if (R) begin
                mq.delete();
                mAck = 0;
                mCap = 0;
            end else begin
                isFull = (mq.size() == DEPTH);
                doPop  = (mq.size() > 0) && out_ready && !clr;
                doPush = !mAck && doneData && !isFull && !clr;
                if (clr) begin
                    mq.delete();
                end else begin
                    if (doPop)  void'(mq.pop_front());
                    if (doPush) mq.push_back({outData, enc_dec});
                end
                if (doPush) mCap++;
                if (mAck && !doneData) mAck = 0;
                else if (doPush)      mAck = 1;
            end
            #1;
            chk("m_readData", readData, mAck);
            chk("m_count", count, mq.size());
            chk("m_full", full, mq.size() == DEPTH);
            chk("m_out_valid", out_valid, mq.size() > 0);
            chk("m_n_captured", n_captured, mCap % 256);
            if (mq.size() > 0) chk("m_head", {out_data, out_enc_dec}, mq[0]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Core-side four-phase transfer of one result; returns at the negedge where readData is seen.
    task automatic sendResult(input logic [31:0] d, input logic t);
        int k;
        k = 0;
        while (readData !== 1'b0 && k < 50) begin
            tick();
            k++;
        end
        doneData = 1'b1;
        outData  = d;
        enc_dec  = t;
        k = 0;
        do begin
            tick();
            k++;
        end while (readData !== 1'b1 && k < 50);
        chk("ack_seen", readData, 1'b1);
        doneData = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_readData", readData, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_n_captured", n_captured, 0);
        chk("rst_out_data", {out_data, out_enc_dec}, 0);
        tick();
        R = 1'b0;

        // Single result: SIMON32/64 ciphertext of 65656877 under key 1918_1110_0908_0100
        doneData = 1'b1; outData = 32'hc69be9bb; enc_dec = 1'b1;
        tick();
        chk("t1_readData", readData, 1'b1);
        chk("t1_out_data", out_data, 32'hc69be9bb);
        chk("t1_out_enc_dec", out_enc_dec, 1'b1);
        chk("t1_count", count, 1);
        doneData = 1'b0;
        tick();
        chk("t1_readData_drop", readData, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_drained", count, 0);

        // Back-pressure: four fill the FIFO, the fifth stalls until one pop
        for (int i = 0; i < 4; i++) sendResult(32'hA000_0000 + i, i[0]);
        chk("t2_full", full, 1'b1);
        chk("t2_count", count, 4);
        tick();
        doneData = 1'b1; outData = 32'hA000_0004; enc_dec = 1'b1;
        repeat (3) tick();
        chk("t2_stall", readData, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_after_pop_count", count, 3);
        chk("t2_after_pop_ack", readData, 1'b0);
        chk("t2_head1", out_data, 32'hA000_0001);
        tick();
        chk("t2_fifth_ack", readData, 1'b1);
        chk("t2_fifth_count", count, 4);
        doneData = 1'b0;
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk("t2_order", out_data, 32'hA000_0000 + j);
            tick();
        end
        out_ready = 1'b0;
        chk("t2_empty", count, 0);

        // Simultaneous push and pop at count=2
        sendResult(32'h3000_0001, 1'b1);
        sendResult(32'h3000_0002, 1'b0);
        tick();
        doneData = 1'b1; outData = 32'h3000_0003; enc_dec = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_count", count, 2);
        chk("t3_ack", readData, 1'b1);
        chk("t3_head", out_data, 32'h3000_0002);
        doneData = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        chk("t3_empty", count, 0);

        // Asynchronous reset during ACK, held result recaptured afterwards
        tick();
        doneData = 1'b1; outData = 32'hB4B4_B4B4; enc_dec = 1'b1;
        tick();
        chk("t4_in_ack", readData, 1'b1);
        #2 R = 1'b1;
        #1;
        chk("t4_async_readData", readData, 1'b0);
        chk("t4_async_count", count, 0);
        chk("t4_async_valid", out_valid, 1'b0);
        chk("t4_async_data", out_data, 0);
        tick();
        R = 1'b0;
        tick();
        chk("t4_recap_ack", readData, 1'b1);
        chk("t4_recap_count", count, 1);
        chk("t4_recap_ncap", n_captured, 1);
        chk("t4_recap_data", out_data, 32'hB4B4_B4B4);
        doneData = 1'b0;

        // clr with count=3 and a pending doneData
        sendResult(32'h5000_0001, 1'b1);
        sendResult(32'h5000_0002, 1'b1);
        tick();
        chk("t5_count3", count, 3);
        doneData = 1'b1; outData = 32'h5000_0003; enc_dec = 1'b0; clr = 1'b1;
        tick();
        chk("t5_cleared", count, 0);
        chk("t5_deferred", readData, 1'b0);
        clr = 1'b0;
        tick();
        chk("t5_capture", count, 1);
        chk("t5_ack", readData, 1'b1);
        doneData = 1'b0;
        sendResult(32'h5000_0004, 1'b1);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        chk("t5_ncap", n_captured, 5);

        // Decrypt pass: five tagged enc_dec=0
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sendResult(32'hD000_0000 + i, 1'b0);
            chk("t6_tag", out_enc_dec, 1'b0);
            chk("t6_data", out_data, 32'hD000_0000 + i);
        end
        tick();
        chk("t6_ncap", n_captured, 10);
        out_ready = 1'b0;

        // Randomized traffic, alternating light and heavy back-pressure
        for (int c = 0; c < 4000; c++) begin
            tick();
            if ((c / 400) % 2 == 0) out_ready = ($urandom_range(0, 3) != 0);
            else                    out_ready = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 59) == 0);
            if (!doneData && !readData && $urandom_range(0, 1) == 1) begin
                doneData = 1'b1;
                outData  = $urandom;
                enc_dec  = $urandom_range(0, 1) == 1;
            end else if (doneData && readData) begin
                doneData = 1'b0;
            end
        end
        tick();
        doneData = 1'b0;
        clr = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
